// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer slice.
package lab3_pkg;

  typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} db_state_t;

  localparam int DB_DEFAULT_CYCLES = 4;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side bundle: raw switch levels in, debounced levels and edge pulses out.
interface switch_debouncer_if;

  logic [1:0] sw_raw;
  logic       i1;
  logic       i2;
  logic [1:0] rise;
  logic [1:0] fall;

  modport master (
    output sw_raw,
    input  i1,
    input  i2,
    input  rise,
    input  fall
  );

  modport slave (
    input  sw_raw,
    output i1,
    output i2,
    output rise,
    output fall
  );

endinterface

// File: rtl/switch_debouncer_channel.sv
// One channel: 2-flop synchronizer, debounce FSM with run counter, registered level and edge pulses.
module debounce_channel
  import lab3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1;
  logic          s2;
  db_state_t     state;
  db_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          level_nx;
  logic          rise_nx;
  logic          fall_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nx;
      cnt   <= cnt_nx;
      level <= level_nx;
      rise  <= rise_nx;
      fall  <= fall_nx;
    end
  end

  // Level and pulses are registered copies of the commit decision, so no
  // combinational path exists from raw to any output.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    level_nx = level;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    unique case (state)
      ST_LOW: begin
        level_nx = 1'b0;
        if (s2) begin
          state_nx = WAIT_HIGH;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        level_nx = 1'b0;
        if (!s2) begin
          state_nx = ST_LOW;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_HIGH;
          cnt_nx   = '0;
          level_nx = 1'b1;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        level_nx = 1'b1;
        if (!s2) begin
          state_nx = WAIT_LOW;
          cnt_nx   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        level_nx = 1'b1;
        if (s2) begin
          state_nx = ST_HIGH;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ST_LOW;
          cnt_nx   = '0;
          level_nx = 1'b0;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = ST_LOW;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/switch_debouncer.sv
// Two independent debounce channels feeding and_gate.i1 / and_gate.i2.
module switch_debouncer
  import lab3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DB_DEFAULT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sw_raw,
  output logic       i1,
  output logic       i2,
  output logic [1:0] rise,
  output logic [1:0] fall
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw_raw[0]),
    .level (i1),
    .rise  (rise[0]),
    .fall  (fall[0])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch2 (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw_raw[1]),
    .level (i2),
    .rise  (rise[1]),
    .fall  (fall[1])
  );

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Two-channel synchronizer and debouncer between the board slide switches/pushbuttons and the `and_gate` inputs `i1`/`i2`. It removes metastability and contact bounce, so the gate under test sees clean levels. It also emits one-cycle edge pulses that a downstream display or counter can use. Both channels are identical and fully independent.

## Interface
- `DEBOUNCE_CYCLES`, default 4 — consecutive synchronized samples of a new level required before the output changes; legal range 2..65535.
- `clk`  input  1  — single system clock; all state is rising-edge triggered.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `sw_raw`  input  2  — raw, asynchronous switch levels; bit 0 is channel 1, bit 1 is channel 2.
- `i1`  output  1  — debounced level of channel 1, registered; drives `and_gate.i1`.
- `i2`  output  1  — debounced level of channel 2, registered; drives `and_gate.i2`.
- `rise`  output  2  — one-cycle pulse when the debounced level goes 0→1, per channel.
- `fall`  output  2  — one-cycle pulse when the debounced level goes 1→0, per channel.

## Operation
- Each channel has a 2-flop synchronizer, `s1` then `s2`, followed by a 4-state FSM and a counter `cnt`.
- FSM states:
  - `ST_LOW`: output 0.
  - `WAIT_HIGH`: output 0, candidate level 1.
  - `ST_HIGH`: output 1.
  - `WAIT_LOW`: output 1, candidate level 0.
- `ST_LOW`: if `s2`=1, go to `WAIT_HIGH` with `cnt`=1; otherwise stay.
- `WAIT_HIGH`:
  - if `s2`=0, return to `ST_LOW` with `cnt`=0 (bounce rejected);
  - else if `cnt`==`DEBOUNCE_CYCLES`-1, go to `ST_HIGH`, set output to 1, pulse `rise`, clear `cnt`;
  - else increment `cnt`.
- `ST_HIGH` and `WAIT_LOW` mirror the above with polarity swapped, and pulse `fall` on commit.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`. `cnt` never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- Outputs are pure functions of registered state; no combinational path from `sw_raw` to any output.
- `rise` and `fall` are never both high on the same channel in the same cycle.

## Timing
- Reset values: `s1`=`s2`=0, FSM=`ST_LOW`, `cnt`=0, `i1`=`i2`=0, `rise`=`fall`=2'b00.
  - Reset takes effect immediately, without waiting for a clock edge.
  - Release is synchronous to the next `clk` edge.
- Latency: let E0 be the edge at which `s1` first captures a new level.
  - `s2` holds the new level from E1.
  - The output changes at edge E(1+`DEBOUNCE_CYCLES`), provided `s2` held the new level at every sampled edge E2..E(1+`DEBOUNCE_CYCLES`).
  - The `rise`/`fall` pulse is high for exactly the cycle after that edge.
- Rejection: a new level held in `s2` for fewer than `DEBOUNCE_CYCLES` sampled edges produces no output change and no pulse.
- Restart: a level returning to the committed value during WAIT goes back to ST and clears `cnt`. A later return to the new level restarts counting from 1.
- Reset mid-WAIT abandons the pending transition; the output stays 0.
- A steady 1 present at reset release is committed, at the earliest, `DEBOUNCE_CYCLES`+2 edges after release, with a `rise` pulse.
- Simultaneous activity on both channels is processed independently, with identical latency.

## Structure
- Shared package `lab3_pkg`:
  - `typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} db_state_t`
  - `localparam int DB_DEFAULT_CYCLES = 4`
- Sub-module `debounce_channel`: one synchronizer, FSM and counter, with ports `clk`, `rst_n`, `raw`, `level`, `rise`, `fall`.
  - `switch_debouncer` instantiates it twice.
  - It maps `level` of channel 1/2 to `i1`/`i2`.

## Test plan
1. Reset and hold: `rst_n`=0 with `sw_raw`=2'b11 → `i1`=`i2`=0, `rise`=`fall`=0 for the whole reset.
2. Clean press, N=4: `sw_raw[0]` 0→1 captured at E0 → `i1` rises at E5, `rise[0]` high for one cycle, `i2` unchanged at 0.
3. Bounce rejection, N=4: `sw_raw[0]` = 1 for 3 cycles, then 0 for 2, then 1 steady → no output change until 5 edges after the final capture. Exactly one `rise` pulse in total.
4. Release: with `i1`=1, `sw_raw[0]` 1→0 → `i1` falls at E5 and `fall[0]` pulses once. `and_gate` output `d` follows `i1`&`i2`.
5. Both channels: `sw_raw` 2'b00→2'b11 in one cycle → `i1` and `i2` rise on the same edge, and `rise`=2'b11 for one cycle.
6. Reset mid-wait: assert `rst_n`=0 two cycles into `WAIT_HIGH` → `i1` stays 0. After release with `sw_raw[0]`=1, `i1` rises 6 edges after release.
